exec_unit: RTL and testbench
============================

EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 Parameter DWIDTH, default 16, SHALL set the AC, memory data and wdata width.
REQ-002 Parameter AWIDTH, default 12, SHALL set the memory and branch address width.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on the rising edge.
REQ-004 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 i_execute  input  1  SHALL be the execute request from the control unit; sampled only in IDLE.
REQ-006 i_add, i_load, i_store, i_branch, i_isz  input  1 each  SHALL be the memory-reference op strobes, sampled with i_execute.
REQ-007 i_clr_ac, i_clr_e, i_comp_ac, i_load_ac, i_cir_r, i_cir_l, i_inc_ac  input  1 each  SHALL be the register-reference op strobes.
REQ-008 i_addr  input  AWIDTH  SHALL be the operand address; i_imm  input  8  SHALL be the load-AC immediate.
REQ-009 o_mem_addr  output  AWIDTH; o_mem_rd  output  1; o_mem_we  output  1; o_mem_wdata  output  DWIDTH  SHALL form the memory request port.
REQ-010 i_mem_rdata  input  DWIDTH; i_mem_valid  input  1  SHALL return read data, variable latency.
REQ-011 o_ac  output  DWIDTH; o_e  output  1  SHALL expose the accumulator and carry/extend bit.
REQ-012 o_ex_done, o_err, o_skip, o_pc_load  output  1 each; o_pc_addr  output  AWIDTH; o_busy  output  1  SHALL report completion and status.

Function
REQ-013 FSM states SHALL be IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE; o_busy = (state != IDLE).
REQ-014 Accept: IDLE and i_execute=1; the 12 op strobes SHALL be checked for exactly-one-hot; i_execute outside IDLE SHALL be ignored.
REQ-015 Zero or multiple strobes at accept SHALL go to DONE with o_err=1 and no change to AC, E or memory.
REQ-016 Register ops SHALL update AC/E at the accept edge, then go to DONE: ex_done in cycle accept+1.
REQ-017 clr_ac: AC=0; clr_e: E=0; comp_ac: AC=~AC; load_ac: AC={zeros,i_imm}; inc_ac: AC=AC+1 mod 2^DWIDTH, E unchanged.
REQ-018 cir_r: AC={E,AC[15:1]}, E=AC[0]; cir_l: AC={AC[14:0],E}, E=AC[15].
REQ-019 add/load/isz SHALL latch i_addr and go to RD_REQ; o_mem_rd=1 for exactly that one cycle with o_mem_addr=latched address, then go to RD_WAIT.
REQ-020 i_mem_valid SHALL be honoured only in RD_WAIT; valid in any other state SHALL be ignored.
REQ-021 RD_WAIT with valid, add: {E,AC} = AC + rdata as a 17-bit sum (E = carry out), then DONE.
REQ-022 RD_WAIT with valid, load: AC = rdata, E unchanged, then DONE.
REQ-023 RD_WAIT with valid, isz: latch rdata+1 mod 2^DWIDTH as wdata, then WR_REQ; skip flag = (result==0).
REQ-024 store SHALL latch i_addr and AC as wdata and go to WR_REQ; o_mem_we=1 for exactly one cycle there, then DONE.
REQ-025 branch SHALL latch i_addr and go to DONE; o_pc_load=1 and o_pc_addr=latched address during DONE.
REQ-026 RD_WAIT timeout: an 8-bit counter SHALL clear on RD_WAIT entry; on the 255th RD_WAIT cycle without valid go to DONE with o_err=1, AC/E/memory unchanged.
REQ-027 DONE SHALL last one cycle with o_ex_done=1, then go to IDLE; o_err, o_skip and o_pc_load SHALL be asserted only in DONE.
REQ-028 o_mem_rd and o_mem_we SHALL never be high together; o_mem_addr and o_mem_wdata SHALL hold their latched values outside request cycles.

Reset
REQ-029 On reset_n=0, state SHALL go to IDLE asynchronously.
REQ-030 On reset_n=0, o_ac, o_e, o_mem_addr, o_mem_wdata, o_pc_addr and the timeout counter SHALL be 0.
REQ-031 On reset_n=0, o_mem_rd, o_mem_we, o_ex_done, o_err, o_skip, o_pc_load and o_busy SHALL be 0.
REQ-032 Reset mid-operation SHALL abort the operation with no further memory request or done pulse; the first accept SHALL be possible on the first rising edge after reset_n rises.

Verification
REQ-033 load_ac imm=0x5A, then cir_l with E=1 -> AC=0x00B5, E=0; each ex_done exactly 1 cycle after accept.
REQ-034 AC=0xFFFF, add, rdata=0x0002 valid 3 cycles after RD_REQ -> AC=0x0001, E=1; one o_mem_rd pulse at addr.
REQ-035 isz addr=0x123, rdata=0xFFFF -> WR_REQ writes 0x0000 to 0x123, o_skip=1 with ex_done; rdata=0x0004 -> writes 0x0005, o_skip=0.
REQ-036 store AC=0xBEEF addr=0x7FF -> o_mem_we one cycle, wdata=0xBEEF; branch addr=0x040 -> o_pc_load=1 with o_pc_addr=0x040 in DONE.
REQ-037 i_add and i_load together -> o_err=1 with ex_done, no memory access; load with valid never asserted -> o_err after 255 RD_WAIT cycles, AC unchanged.
REQ-038 reset_n low during RD_WAIT -> all outputs 0 immediately, a late i_mem_valid is ignored, and the next op completes normally.

Source files
------------

// File: rtl/exec_unit.sv
`default_nettype none
// ============================================================================
//  Module   : exec_unit
//  Purpose  : Instruction execute unit. Accepts one memory-reference or
//             register-reference operation per request, runs it against an
//             accumulator (AC) and extend bit (E), issues the needed memory
//             read/write, and reports completion, errors, skip and branch.
//  Ports    : clk, reset_n           - clock, async active-low reset
//             i_execute + op strobes - request and exactly-one-hot op select
//             i_addr, i_imm          - operand address, load-AC immediate
//             o_mem_* / i_mem_*      - single-request memory port
//             o_ac, o_e              - accumulator and extend bit
//             o_ex_done, o_err, o_skip, o_pc_load, o_pc_addr, o_busy - status
//  Revision : 1.0 - initial release
// ============================================================================
module exec_unit #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 12
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_execute,
  input  logic              i_add,
  input  logic              i_load,
  input  logic              i_store,
  input  logic              i_branch,
  input  logic              i_isz,
  input  logic              i_clr_ac,
  input  logic              i_clr_e,
  input  logic              i_comp_ac,
  input  logic              i_load_ac,
  input  logic              i_cir_r,
  input  logic              i_cir_l,
  input  logic              i_inc_ac,
  input  logic [AWIDTH-1:0] i_addr,
  input  logic [7:0]        i_imm,
  output logic [AWIDTH-1:0] o_mem_addr,
  output logic              o_mem_rd,
  output logic              o_mem_we,
  output logic [DWIDTH-1:0] o_mem_wdata,
  input  logic [DWIDTH-1:0] i_mem_rdata,
  input  logic              i_mem_valid,
  output logic [DWIDTH-1:0] o_ac,
  output logic              o_e,
  output logic              o_ex_done,
  output logic              o_err,
  output logic              o_skip,
  output logic              o_pc_load,
  output logic [AWIDTH-1:0] o_pc_addr,
  output logic              o_busy
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    DONE    = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD  = 2'd0,
    OP_LOAD = 2'd1,
    OP_ISZ  = 2'd2
  } rdop_t;

  // Last RD_WAIT cycle index (counter starts at 0 on entry -> 255 cycles).
  localparam logic [7:0] c_TIMEOUT_LAST = 8'd254;

  state_t              state_q, state_d;
  rdop_t               op_q, op_d;
  logic [DWIDTH-1:0]   ac_q, ac_d;
  logic                e_q, e_d;
  logic [AWIDTH-1:0]   addr_q, addr_d;
  logic [DWIDTH-1:0]   wdata_q, wdata_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                skip_q, skip_d;
  logic                pcl_q, pcl_d;

  logic [11:0]         w_strobes;
  logic                w_onehot;
  logic [DWIDTH:0]     w_sum;
  logic [DWIDTH-1:0]   w_rd_inc;

  assign w_strobes = {i_add, i_load, i_store, i_branch, i_isz, i_clr_ac,
                      i_clr_e, i_comp_ac, i_load_ac, i_cir_r, i_cir_l, i_inc_ac};
  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  assign w_onehot  = (w_strobes != 12'd0) &&
                     ((w_strobes & (w_strobes - 12'd1)) == 12'd0);
  assign w_sum     = {1'b0, ac_q} + {1'b0, i_mem_rdata};
  assign w_rd_inc  = i_mem_rdata + DWIDTH'(1);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    ac_d    = ac_q;
    e_d     = e_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    skip_d  = skip_q;
    pcl_d   = pcl_q;
    case (state_q)
      IDLE: begin
        if (i_execute) begin
          err_d  = 1'b0;
          skip_d = 1'b0;
          pcl_d  = 1'b0;
          if (!w_onehot) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else if (i_add || i_load || i_isz) begin
            addr_d  = i_addr;
            op_d    = i_add ? OP_ADD : (i_load ? OP_LOAD : OP_ISZ);
            state_d = RD_REQ;
          end else if (i_store) begin
            addr_d  = i_addr;
            wdata_d = ac_q;
            state_d = WR_REQ;
          end else if (i_branch) begin
            addr_d  = i_addr;
            pcl_d   = 1'b1;
            state_d = DONE;
          end else begin
            // Register-reference op: strobes are one-hot here, so at most
            // one of the following assignments takes effect.
            state_d = DONE;
            if (i_clr_ac)  ac_d = '0;
            if (i_clr_e)   e_d  = 1'b0;
            if (i_comp_ac) ac_d = ~ac_q;
            if (i_load_ac) ac_d = {{(DWIDTH-8){1'b0}}, i_imm};
            if (i_cir_r) begin
              ac_d = {e_q, ac_q[DWIDTH-1:1]};
              e_d  = ac_q[0];
            end
            if (i_cir_l) begin
              ac_d = {ac_q[DWIDTH-2:0], e_q};
              e_d  = ac_q[DWIDTH-1];
            end
            if (i_inc_ac)  ac_d = ac_q + DWIDTH'(1);
          end
        end
      end
      RD_REQ: begin
        cnt_d   = 8'd0;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (i_mem_valid) begin
          state_d = DONE;
          case (op_q)
            OP_ADD:  {e_d, ac_d} = w_sum;
            OP_LOAD: ac_d = i_mem_rdata;
            default: begin
              wdata_d = w_rd_inc;
              skip_d  = (w_rd_inc == '0);
              state_d = WR_REQ;
            end
          endcase
        end else if (cnt_q == c_TIMEOUT_LAST) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      WR_REQ:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      op_q    <= OP_ADD;
      ac_q    <= '0;
      e_q     <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= 8'd0;
      err_q   <= 1'b0;
      skip_q  <= 1'b0;
      pcl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ac_q    <= ac_d;
      e_q     <= e_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      skip_q  <= skip_d;
      pcl_q   <= pcl_d;
    end
  end

  // Request/status strobes decode straight from state, so each is a clean
  // single-cycle pulse and rd/we are mutually exclusive by construction.
  assign o_mem_rd    = (state_q == RD_REQ);
  assign o_mem_we    = (state_q == WR_REQ);
  assign o_ex_done   = (state_q == DONE);
  assign o_busy      = (state_q != IDLE);
  assign o_err       = o_ex_done & err_q;
  assign o_skip      = o_ex_done & skip_q;
  assign o_pc_load   = o_ex_done & pcl_q;
  assign o_mem_addr  = addr_q;
  assign o_pc_addr   = addr_q;
  assign o_mem_wdata = wdata_q;
  assign o_ac        = ac_q;
  assign o_e         = e_q;

endmodule
`default_nettype wire

// File: tb/tb_exec_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_exec_unit
//  Purpose  : Directed scoreboard bench for exec_unit. Stimulus pushes the
//             expected memory pulses and completions; a negedge monitor pops
//             and compares whenever the DUT presents one.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_exec_unit;
  localparam int DW = 16;
  localparam int AW = 12;

  localparam logic [11:0] S_ADD = 12'h800, S_LOAD = 12'h400, S_STORE = 12'h200;
  localparam logic [11:0] S_BRANCH = 12'h100, S_ISZ = 12'h080, S_CLRAC = 12'h040;
  localparam logic [11:0] S_CLRE = 12'h020, S_COMP = 12'h010, S_LDAC = 12'h008;
  localparam logic [11:0] S_CIRR = 12'h004, S_CIRL = 12'h002, S_INC = 12'h001;

  localparam int K_RD = 0, K_WR = 1, K_DONE = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  logic          i_execute = 1'b0;
  logic [11:0]   strb = 12'd0;
  logic          i_add, i_load, i_store, i_branch, i_isz, i_clr_ac, i_clr_e;
  logic          i_comp_ac, i_load_ac, i_cir_r, i_cir_l, i_inc_ac;
  logic [AW-1:0] i_addr = '0;
  logic [7:0]    i_imm = 8'd0;
  logic [DW-1:0] i_mem_rdata = '0;
  logic          i_mem_valid = 1'b0;
  logic [AW-1:0] o_mem_addr, o_pc_addr;
  logic [DW-1:0] o_mem_wdata, o_ac;
  logic          o_mem_rd, o_mem_we, o_e, o_ex_done, o_err, o_skip, o_pc_load, o_busy;

  assign {i_add, i_load, i_store, i_branch, i_isz, i_clr_ac, i_clr_e,
          i_comp_ac, i_load_ac, i_cir_r, i_cir_l, i_inc_ac} = strb;

  exec_unit #(.DWIDTH(DW), .AWIDTH(AW)) dut (
    .clk(clk), .reset_n(reset_n), .i_execute(i_execute),
    .i_add(i_add), .i_load(i_load), .i_store(i_store), .i_branch(i_branch),
    .i_isz(i_isz), .i_clr_ac(i_clr_ac), .i_clr_e(i_clr_e), .i_comp_ac(i_comp_ac),
    .i_load_ac(i_load_ac), .i_cir_r(i_cir_r), .i_cir_l(i_cir_l), .i_inc_ac(i_inc_ac),
    .i_addr(i_addr), .i_imm(i_imm),
    .o_mem_addr(o_mem_addr), .o_mem_rd(o_mem_rd), .o_mem_we(o_mem_we),
    .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata), .i_mem_valid(i_mem_valid),
    .o_ac(o_ac), .o_e(o_e), .o_ex_done(o_ex_done), .o_err(o_err), .o_skip(o_skip),
    .o_pc_load(o_pc_load), .o_pc_addr(o_pc_addr), .o_busy(o_busy)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int            kind;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DW-1:0] ac;
    logic          e, err, skip, pcl;
    int            cyc;
  } ev_t;

  ev_t q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic ev_t mk(int kind, logic [AW-1:0] addr, logic [DW-1:0] data,
                             logic [DW-1:0] ac, logic e, logic err, logic skip,
                             logic pcl, int c);
    ev_t ev;
    ev.kind = kind; ev.addr = addr; ev.data = data; ev.ac = ac; ev.e = e;
    ev.err = err; ev.skip = skip; ev.pcl = pcl; ev.cyc = c;
    return ev;
  endfunction

  task automatic handle(input int kind);
    ev_t ev;
    if (q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_event: got kind %0d, expected none (t=%0t)", kind, $time);
    end else begin
      ev = q.pop_front();
      chk("event_kind", kind, ev.kind);
      if (ev.cyc >= 0) chk("event_cycle", cyc, ev.cyc);
      if (kind == ev.kind) begin
        if (kind == K_RD) chk("rd_addr", 32'(o_mem_addr), 32'(ev.addr));
        if (kind == K_WR) begin
          chk("wr_addr", 32'(o_mem_addr), 32'(ev.addr));
          chk("wr_data", 32'(o_mem_wdata), 32'(ev.data));
        end
        if (kind == K_DONE) begin
          chk("done_ac", 32'(o_ac), 32'(ev.ac));
          chk("done_e", 32'(o_e), 32'(ev.e));
          chk("done_err", 32'(o_err), 32'(ev.err));
          chk("done_skip", 32'(o_skip), 32'(ev.skip));
          chk("done_pcload", 32'(o_pc_load), 32'(ev.pcl));
          chk("done_busy", 32'(o_busy), 32'd1);
          if (ev.pcl) chk("pc_addr", 32'(o_pc_addr), 32'(ev.addr));
        end
      end
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (reset_n) begin
      if (o_mem_rd && o_mem_we) chk("rd_we_overlap", 32'd1, 32'd0);
      if (!o_ex_done && (o_err || o_skip || o_pc_load))
        chk("status_outside_done", {29'd0, o_err, o_skip, o_pc_load}, 32'd0);
      if (o_mem_rd)  handle(K_RD);
      if (o_mem_we)  handle(K_WR);
      if (o_ex_done) handle(K_DONE);
    end
  end

  // Drive one request at the current negedge; c0 is the cycle count before
  // the accept edge, so anything caused by the accept shows at c0+1.
  task automatic issue(input logic [11:0] s, input logic [AW-1:0] a,
                       input logic [7:0] im, output int c0);
    c0 = cyc;
    i_execute = 1'b1; strb = s; i_addr = a; i_imm = im;
    @(posedge clk); #1;
    i_execute = 1'b0; strb = 12'd0;
  endtask

  task automatic wait_rd();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_mem_rd && n < 20);
    if (!o_mem_rd) chk("rd_timeout", 32'd0, 32'd1);
  endtask

  // Returns rdata lat cycles after the RD_REQ cycle; optionally also waves a
  // bogus valid during RD_REQ itself, which must be ignored.
  task automatic respond(input logic [DW-1:0] d, input int lat, input logic garb);
    wait_rd();
    if (garb) begin i_mem_valid = 1'b1; i_mem_rdata = 16'h1111; end
    @(negedge clk);
    i_mem_valid = 1'b0;
    repeat (lat - 1) @(negedge clk);
    i_mem_valid = 1'b1; i_mem_rdata = d;
    @(posedge clk); #1;
    i_mem_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_ex_done && n < budget);
    if (!o_ex_done) chk("done_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_ac", 32'(o_ac), 32'd0);
    chk("rst_e", 32'(o_e), 32'd0);
    chk("rst_mem_addr", 32'(o_mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(o_mem_wdata), 32'd0);
    chk("rst_pc_addr", 32'(o_pc_addr), 32'd0);
    chk("rst_strobes", {25'd0, o_mem_rd, o_mem_we, o_ex_done, o_err, o_skip,
                        o_pc_load, o_busy}, 32'd0);
  endtask

  initial begin
    int c;
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    #1 chk_reset_outputs();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Get E=1: AC=1, rotate right -> AC=0, E=1.
    issue(S_LDAC, 12'h0, 8'h01, c); q.push_back(mk(K_DONE, 0, 0, 16'h0001, 0, 0, 0, 0, c + 1));
    wait_done(5);
    issue(S_CIRR, 12'h0, 8'h00, c); q.push_back(mk(K_DONE, 0, 0, 16'h0000, 1, 0, 0, 0, c + 1));
    wait_done(5);
    issue(S_LDAC, 12'h0, 8'h5A, c); q.push_back(mk(K_DONE, 0, 0, 16'h005A, 1, 0, 0, 0, c + 1));
    wait_done(5);
    issue(S_CIRL, 12'h0, 8'h00, c); q.push_back(mk(K_DONE, 0, 0, 16'h00B5, 0, 0, 0, 0, c + 1));
    wait_done(5);

    // AC=0xFFFF then add 0x0002 -> AC=0x0001, E=1.
    issue(S_CLRAC, 12'h0, 8'h00, c); q.push_back(mk(K_DONE, 0, 0, 16'h0000, 0, 0, 0, 0, c + 1));
    wait_done(5);
    issue(S_COMP, 12'h0, 8'h00, c); q.push_back(mk(K_DONE, 0, 0, 16'hFFFF, 0, 0, 0, 0, c + 1));
    wait_done(5);
    issue(S_ADD, 12'h0A5, 8'h00, c);
    q.push_back(mk(K_RD, 12'h0A5, 0, 0, 0, 0, 0, 0, c + 1));
    q.push_back(mk(K_DONE, 0, 0, 16'h0001, 1, 0, 0, 0, -1));
    respond(16'h0002, 3, 1'b0);
    wait_done(10);

    issue(S_INC, 12'h0, 8'h00, c); q.push_back(mk(K_DONE, 0, 0, 16'h0002, 1, 0, 0, 0, c + 1));
    wait_done(5);

    // isz wrap to zero -> skip; isz non-zero -> no skip.
    issue(S_ISZ, 12'h123, 8'h00, c);
    q.push_back(mk(K_RD, 12'h123, 0, 0, 0, 0, 0, 0, c + 1));
    q.push_back(mk(K_WR, 12'h123, 16'h0000, 0, 0, 0, 0, 0, -1));
    q.push_back(mk(K_DONE, 0, 0, 16'h0002, 1, 0, 1, 0, -1));
    respond(16'hFFFF, 2, 1'b0);
    wait_done(10);
    issue(S_ISZ, 12'h123, 8'h00, c);
    q.push_back(mk(K_RD, 12'h123, 0, 0, 0, 0, 0, 0, c + 1));
    q.push_back(mk(K_WR, 12'h123, 16'h0005, 0, 0, 0, 0, 0, -1));
    q.push_back(mk(K_DONE, 0, 0, 16'h0002, 1, 0, 0, 0, -1));
    respond(16'h0004, 1, 1'b0);
    wait_done(10);

    // load 0xBEEF with a stray valid during RD_REQ (must be ignored).
    issue(S_LOAD, 12'h200, 8'h00, c);
    q.push_back(mk(K_RD, 12'h200, 0, 0, 0, 0, 0, 0, c + 1));
    q.push_back(mk(K_DONE, 0, 0, 16'hBEEF, 1, 0, 0, 0, -1));
    respond(16'hBEEF, 2, 1'b1);
    wait_done(10);

    issue(S_STORE, 12'h7FF, 8'h00, c);
    q.push_back(mk(K_WR, 12'h7FF, 16'hBEEF, 0, 0, 0, 0, 0, c + 1));
    q.push_back(mk(K_DONE, 0, 0, 16'hBEEF, 1, 0, 0, 0, c + 2));
    wait_done(5);

    issue(S_BRANCH, 12'h040, 8'h00, c);
    q.push_back(mk(K_DONE, 12'h040, 0, 16'hBEEF, 1, 0, 0, 1, c + 1));
    wait_done(5);

    // Illegal strobe combinations: two strobes, then none.
    issue(S_ADD | S_LOAD, 12'h111, 8'h00, c);
    q.push_back(mk(K_DONE, 0, 0, 16'hBEEF, 1, 1, 0, 0, c + 1));
    wait_done(5);
    issue(12'd0, 12'h111, 8'h00, c);
    q.push_back(mk(K_DONE, 0, 0, 16'hBEEF, 1, 1, 0, 0, c + 1));
    wait_done(5);

    // Read timeout: RD_REQ at c+1, RD_WAIT c+2..c+256, DONE at c+257.
    issue(S_LOAD, 12'h300, 8'h00, c);
    q.push_back(mk(K_RD, 12'h300, 0, 0, 0, 0, 0, 0, c + 1));
    q.push_back(mk(K_DONE, 0, 0, 16'hBEEF, 1, 1, 0, 0, c + 257));
    wait_done(300);

    // Reset during RD_WAIT, late valid, then an op right after release.
    issue(S_LOAD, 12'h301, 8'h00, c);
    q.push_back(mk(K_RD, 12'h301, 0, 0, 0, 0, 0, 0, c + 1));
    wait_rd();
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 chk_reset_outputs();
    i_mem_valid = 1'b1; i_mem_rdata = 16'h7777;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    issue(S_LDAC, 12'h0, 8'h42, c);
    q.push_back(mk(K_DONE, 0, 0, 16'h0042, 0, 0, 0, 0, c + 1));
    i_mem_valid = 1'b0;
    wait_done(5);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "global timeout");
  end
endmodule
`default_nettype wire
